ball_mover: RTL and testbench



---
 rtl/ball_mover.sv | 221 ++++++++++++++++++++++
 tb/tb_ball_mover.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ball_mover.sv
// ============================================================================
// Module   : ball_mover
// Purpose  : Ball motion engine: serve hold, per-frame position integration,
//            wall bounces, paddle deflection and miss detection.
// Options  : BALL_SPEEDUP_EN - each accepted paddle hit speeds up dx.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ball_mover #(
    parameter int X_MIN      = 8,
    parameter int X_MAX      = 631,
    parameter int Y_MIN      = 8,
    parameter int Y_MAX      = 471,
    parameter int SERVE_X    = 320,
    parameter int SERVE_Y    = 240,
    parameter int DX_SPEED   = 2,
    parameter int SHIFT      = 3,
    parameter int VMAX       = 7,
    parameter int SERVE_WAIT = 60,
    parameter int DX_MAX     = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame,
    input  logic       serve,
    input  logic       collide_l,
    input  logic       collide_r,
    input  logic [9:0] deflect,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       miss_l,
    output logic       miss_r,
    output logic       in_play
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_FLY  = 2'd2,
        S_MISS = 2'd3
    } state_t;

    localparam logic signed [10:0] c_X_MIN    = 11'(X_MIN);
    localparam logic signed [10:0] c_X_MAX    = 11'(X_MAX);
    localparam logic signed [10:0] c_Y_MIN    = 11'(Y_MIN);
    localparam logic signed [10:0] c_Y_MAX    = 11'(Y_MAX);
    localparam logic [9:0]         c_SERVE_X  = 10'(SERVE_X);
    localparam logic [9:0]         c_SERVE_Y  = 10'(SERVE_Y);
    localparam logic [3:0]         c_DX_SPEED = 4'(DX_SPEED);
    localparam logic [3:0]         c_VMAX     = 4'(VMAX);
    localparam logic [5:0]         c_WAIT_END = 6'(SERVE_WAIT - 1);

    state_t     r_state;
    logic [9:0] r_ball_x;
    logic [9:0] r_ball_y;
    logic       r_dir_x;
    logic [3:0] r_vy_mag;
    logic       r_vy_neg;
    logic [3:0] r_dx;
    logic [5:0] r_wait_cnt;
    logic       r_serve_dir;
    logic       r_miss_l;
    logic       r_miss_r;

    state_t            w_state_nxt;
    logic [9:0]        w_ball_x_nxt;
    logic [9:0]        w_ball_y_nxt;
    logic              w_dir_x_nxt;
    logic [3:0]        w_vy_mag_nxt;
    logic              w_vy_neg_nxt;
    logic [3:0]        w_dx_nxt;
    logic [5:0]        w_wait_cnt_nxt;
    logic              w_serve_dir_nxt;
    logic              w_miss_l_nxt;
    logic              w_miss_r_nxt;

    logic              w_collide_ok;
    logic [8:0]        w_vy_raw;
    logic [3:0]        w_vy_clamp;
    logic signed [10:0] w_x_new;
    logic signed [10:0] w_y_new;

    // A collide only counts when the ball is heading toward that paddle.
    assign w_collide_ok = (collide_l & ~r_dir_x) | (collide_r & r_dir_x);
    assign w_vy_raw     = deflect[8:0] >> SHIFT;
    assign w_vy_clamp   = (w_vy_raw > 9'(VMAX)) ? c_VMAX : w_vy_raw[3:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ball_x    <= c_SERVE_X;
            r_ball_y    <= c_SERVE_Y;
            r_dir_x     <= 1'b1;
            r_vy_mag    <= 4'd0;
            r_vy_neg    <= 1'b0;
            r_dx        <= c_DX_SPEED;
            r_wait_cnt  <= 6'd0;
            r_serve_dir <= 1'b1;
            r_miss_l    <= 1'b0;
            r_miss_r    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ball_x    <= w_ball_x_nxt;
            r_ball_y    <= w_ball_y_nxt;
            r_dir_x     <= w_dir_x_nxt;
            r_vy_mag    <= w_vy_mag_nxt;
            r_vy_neg    <= w_vy_neg_nxt;
            r_dx        <= w_dx_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_serve_dir <= w_serve_dir_nxt;
            r_miss_l    <= w_miss_l_nxt;
            r_miss_r    <= w_miss_r_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_ball_x_nxt    = r_ball_x;
        w_ball_y_nxt    = r_ball_y;
        w_dir_x_nxt     = r_dir_x;
        w_vy_mag_nxt    = r_vy_mag;
        w_vy_neg_nxt    = r_vy_neg;
        w_dx_nxt        = r_dx;
        w_wait_cnt_nxt  = r_wait_cnt;
        w_serve_dir_nxt = r_serve_dir;
        w_miss_l_nxt    = 1'b0;
        w_miss_r_nxt    = 1'b0;
        w_x_new         = 11'sd0;
        w_y_new         = 11'sd0;

        case (r_state)
            S_IDLE: begin
                w_ball_x_nxt = c_SERVE_X;
                w_ball_y_nxt = c_SERVE_Y;
                if (serve) begin
                    w_state_nxt = S_WAIT;
                end
            end

            S_WAIT: begin
                w_ball_x_nxt = c_SERVE_X;
                w_ball_y_nxt = c_SERVE_Y;
                if (frame) begin
                    if (r_wait_cnt == c_WAIT_END) begin
                        w_wait_cnt_nxt = 6'd0;
                        w_vy_mag_nxt   = 4'd0;
                        w_dx_nxt       = c_DX_SPEED;
                        w_dir_x_nxt    = r_serve_dir;
                        w_state_nxt    = S_FLY;
                    end else begin
                        w_wait_cnt_nxt = r_wait_cnt + 6'd1;
                    end
                end
            end

            S_FLY: begin
                if (w_collide_ok) begin
                    w_dir_x_nxt  = ~r_dir_x;
                    w_vy_neg_nxt = deflect[9];
                    w_vy_mag_nxt = w_vy_clamp;
`ifdef BALL_SPEEDUP_EN
                    w_dx_nxt = (r_dx >= 4'(DX_MAX)) ? 4'(DX_MAX) : r_dx + 4'd1;
`else
                    w_dx_nxt = r_dx;
`endif
                end

                // The step uses post-collide velocity so a same-cycle hit
                // already moves the ball away from the paddle.
                if (frame) begin
                    w_x_new = w_dir_x_nxt ? $signed({1'b0, r_ball_x}) + $signed({7'd0, w_dx_nxt})
                                          : $signed({1'b0, r_ball_x}) - $signed({7'd0, w_dx_nxt});
                    w_y_new = w_vy_neg_nxt ? $signed({1'b0, r_ball_y}) - $signed({7'd0, w_vy_mag_nxt})
                                           : $signed({1'b0, r_ball_y}) + $signed({7'd0, w_vy_mag_nxt});

                    if (w_vy_neg_nxt && (w_y_new < c_Y_MIN)) begin
                        w_ball_y_nxt = c_Y_MIN[9:0];
                        w_vy_neg_nxt = 1'b0;
                    end else if (!w_vy_neg_nxt && (w_y_new > c_Y_MAX)) begin
                        w_ball_y_nxt = c_Y_MAX[9:0];
                        w_vy_neg_nxt = 1'b1;
                    end else begin
                        w_ball_y_nxt = w_y_new[9:0];
                    end

                    if (!w_dir_x_nxt && (w_x_new < c_X_MIN)) begin
                        w_miss_l_nxt    = 1'b1;
                        w_serve_dir_nxt = 1'b0;
                        w_state_nxt     = S_MISS;
                    end else if (w_dir_x_nxt && (w_x_new > c_X_MAX)) begin
                        w_miss_r_nxt    = 1'b1;
                        w_serve_dir_nxt = 1'b1;
                        w_state_nxt     = S_MISS;
                    end else begin
                        w_ball_x_nxt = w_x_new[9:0];
                    end
                end
            end

            S_MISS: begin
                w_ball_x_nxt = c_SERVE_X;
                w_ball_y_nxt = c_SERVE_Y;
                w_state_nxt  = S_WAIT;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign ball_x  = r_ball_x;
    assign ball_y  = r_ball_y;
    assign miss_l  = r_miss_l;
    assign miss_r  = r_miss_r;
    assign in_play = (r_state == S_FLY);

endmodule

`default_nettype wire

// File: tb/tb_ball_mover.sv
// ============================================================================
// Module   : tb_ball_mover
// Purpose  : Directed vector bench for ball_mover (serve, bounce, miss, reset).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ball_mover;

    logic       clk;
    logic       reset;
    logic       frame;
    logic       serve;
    logic       collide_l;
    logic       collide_r;
    logic [9:0] deflect;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       miss_l;
    logic       miss_r;
    logic       in_play;

    int n_vec;
    int n_miss;

    typedef struct {
        logic       fr;
        logic       sv;
        logic       cl;
        logic       cr;
        logic [9:0] df;
        int         n;
        logic [9:0] ex;
        logic [9:0] ey;
        logic       ep;
        logic       eml;
        logic       emr;
    } vec_t;

    vec_t vt[$];

    ball_mover dut (
        .clk       (clk),
        .reset     (reset),
        .frame     (frame),
        .serve     (serve),
        .collide_l (collide_l),
        .collide_r (collide_r),
        .deflect   (deflect),
        .ball_x    (ball_x),
        .ball_y    (ball_y),
        .miss_l    (miss_l),
        .miss_r    (miss_r),
        .in_play   (in_play)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(input logic fr, input logic sv, input logic cl, input logic cr,
                                input logic [9:0] df, input int n,
                                input logic [9:0] ex, input logic [9:0] ey,
                                input logic ep, input logic eml, input logic emr);
        vec_t v;
        v.fr = fr; v.sv = sv; v.cl = cl; v.cr = cr; v.df = df; v.n = n;
        v.ex = ex; v.ey = ey; v.ep = ep; v.eml = eml; v.emr = emr;
        vt.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [9:0] ex, input logic [9:0] ey,
                       input logic ep, input logic eml, input logic emr);
        n_vec++;
        if (ball_x !== ex) begin
            n_miss++;
            $display("FAIL %s ball_x got %0d expected %0d", nm, ball_x, ex);
        end
        if (ball_y !== ey) begin
            n_miss++;
            $display("FAIL %s ball_y got %0d expected %0d", nm, ball_y, ey);
        end
        if (in_play !== ep) begin
            n_miss++;
            $display("FAIL %s in_play got %b expected %b", nm, in_play, ep);
        end
        if (miss_l !== eml) begin
            n_miss++;
            $display("FAIL %s miss_l got %b expected %b", nm, miss_l, eml);
        end
        if (miss_r !== emr) begin
            n_miss++;
            $display("FAIL %s miss_r got %b expected %b", nm, miss_r, emr);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        frame     = v.fr;
        serve     = v.sv;
        collide_l = v.cl;
        collide_r = v.cr;
        deflect   = v.df;
        repeat (v.n) @(posedge clk);
        #1;
        frame     = 1'b0;
        serve     = 1'b0;
        collide_l = 1'b0;
        collide_r = 1'b0;
        deflect   = 10'd0;
        chk($sformatf("vec%0d", idx), v.ex, v.ey, v.ep, v.eml, v.emr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        n_vec     = 0;
        n_miss    = 0;
        reset     = 1'b1;
        frame     = 1'b0;
        serve     = 1'b0;
        collide_l = 1'b0;
        collide_r = 1'b0;
        deflect   = 10'd0;

        //   fr sv cl cr deflect  n    x    y  play ml mr
        add(0, 1, 0, 0, 10'h000, 1,   320, 240, 0, 0, 0);  // serve -> WAIT
        add(1, 0, 0, 0, 10'h000, 59,  320, 240, 0, 0, 0);
        add(1, 0, 0, 0, 10'h000, 1,   320, 240, 1, 0, 0);  // 60th frame -> FLY
        add(1, 0, 0, 0, 10'h000, 1,   322, 240, 1, 0, 0);
`ifndef BALL_SPEEDUP_EN
        add(0, 0, 0, 1, 10'h028, 1,   322, 240, 1, 0, 0);  // dir left, vy 5 down
        add(1, 0, 0, 0, 10'h000, 1,   320, 245, 1, 0, 0);
        add(1, 0, 0, 1, 10'h0FF, 1,   318, 250, 1, 0, 0);  // wrong-side collide ignored
        add(0, 0, 1, 0, 10'h0FF, 1,   318, 250, 1, 0, 0);  // dir right, vy clamp 7
        add(1, 0, 0, 0, 10'h000, 1,   320, 257, 1, 0, 0);
        add(1, 0, 0, 1, 10'h228, 1,   318, 252, 1, 0, 0);  // collide+frame, up 5
        add(1, 0, 1, 1, 10'h018, 1,   320, 255, 1, 0, 0);  // both: only collide_l acts
        add(0, 0, 0, 1, 10'h228, 1,   320, 255, 1, 0, 0);  // left, up 5
        add(1, 0, 0, 0, 10'h000, 49,  222, 10,  1, 0, 0);
        add(1, 0, 0, 0, 10'h000, 1,   220, 8,   1, 0, 0);  // top wall clamp
        add(1, 0, 0, 0, 10'h000, 1,   218, 13,  1, 0, 0);
        add(0, 0, 1, 0, 10'h000, 1,   218, 13,  1, 0, 0);  // vy 0, right
        add(0, 0, 0, 1, 10'h000, 1,   218, 13,  1, 0, 0);  // left
        add(1, 0, 0, 0, 10'h000, 104, 10,  13,  1, 0, 0);
        add(1, 0, 0, 0, 10'h000, 1,   8,   13,  1, 0, 0);  // x'=X_MIN is not a miss
        add(1, 0, 0, 0, 10'h000, 1,   8,   13,  0, 1, 0);  // left miss, x held
        add(0, 0, 0, 0, 10'h000, 1,   320, 240, 0, 0, 0);  // reload, pulse gone
        add(1, 0, 0, 0, 10'h000, 59,  320, 240, 0, 0, 0);
        add(1, 0, 0, 0, 10'h000, 1,   320, 240, 1, 0, 0);
        add(1, 0, 0, 0, 10'h000, 1,   318, 240, 1, 0, 0);  // serves toward the loser
        add(0, 0, 1, 0, 10'h038, 1,   318, 240, 1, 0, 0);  // right, vy 7 down
        add(1, 0, 0, 0, 10'h000, 33,  384, 471, 1, 0, 0);  // y'=Y_MAX is not clamped
        add(1, 0, 0, 0, 10'h000, 1,   386, 471, 1, 0, 0);  // bottom wall clamp
        add(1, 0, 0, 0, 10'h000, 1,   388, 464, 1, 0, 0);
        add(0, 0, 1, 1, 10'h000, 1,   388, 464, 1, 0, 0);  // both: only collide_r acts
        add(0, 0, 1, 0, 10'h000, 1,   388, 464, 1, 0, 0);  // back to right, vy 0
        add(1, 0, 0, 0, 10'h000, 121, 630, 464, 1, 0, 0);
        add(1, 0, 0, 0, 10'h000, 1,   630, 464, 0, 0, 1);  // right miss, x held
        add(0, 0, 0, 0, 10'h000, 1,   320, 240, 0, 0, 0);
        add(0, 1, 0, 0, 10'h000, 1,   320, 240, 0, 0, 0);  // serve in WAIT ignored
        add(1, 0, 0, 0, 10'h000, 59,  320, 240, 0, 0, 0);
        add(1, 0, 0, 0, 10'h000, 1,   320, 240, 1, 0, 0);
        add(1, 0, 0, 0, 10'h000, 1,   322, 240, 1, 0, 0);
`else
        add(0, 0, 0, 1, 10'h000, 1,   322, 240, 1, 0, 0);  // dx 3
        add(0, 0, 1, 0, 10'h000, 1,   322, 240, 1, 0, 0);  // dx 4
        add(0, 0, 0, 1, 10'h000, 1,   322, 240, 1, 0, 0);  // dx 5
        add(0, 0, 1, 0, 10'h000, 1,   322, 240, 1, 0, 0);  // dx 6
        add(0, 0, 0, 1, 10'h000, 1,   322, 240, 1, 0, 0);  // dx stays 6
        add(1, 0, 0, 0, 10'h000, 1,   316, 240, 1, 0, 0);
        add(1, 0, 1, 0, 10'h000, 1,   322, 240, 1, 0, 0);  // still 6 after another hit
        add(1, 0, 0, 0, 10'h000, 1,   328, 240, 1, 0, 0);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("reset_hold", 10'd320, 10'd240, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_idle", 10'd320, 10'd240, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < vt.size(); i++) begin
            apply(vt[i], i);
        end

        // Asynchronous reset while flying, checked before any clock edge.
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("async_reset", 10'd320, 10'd240, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        frame = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        frame = 1'b0;
        chk("post_reset_idle", 10'd320, 10'd240, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
